pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side counterpart of the CPU board's input edge limiter. The limiter turns a held button into a one-cycle pulse. This block turns one-cycle event pulses from the datapath into visible fixed-width LED pulses, each followed by a dark gap. It sits between CPU/debug event strobes (instruction retired, step done, trap) and the board LED pins. Events that arrive while a pulse is showing are counted and replayed, so none are lost up to a saturating limit.

## Interface
- ON_CYCLES, 8, LED high time per event in clk cycles (≥1; board top overrides to ~25_000_000)
- GAP_CYCLES, 4, forced LED-low time after each pulse (≥1)
- MAX_PENDING, 3, saturation limit of the queued-event counter (≥1)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- event_i  input  1  event strobe, one count per high cycle
- clear  input  1  synchronous abort: flush queue, drop overflow, return to idle
- led  output  1  stretched pulse output
- busy  output  1  high whenever state ≠ IDLE
- pending  output  $clog2(MAX_PENDING+1)  queued events not yet shown
- overflow  output  1  sticky, set when an event is dropped at saturation

## Operation
- States:
  - IDLE: led=0.
  - ON: led=1.
  - GAP: led=0.
- All outputs are registered. led is decoded from the registered state.
- IDLE + event_i → ON. The timer loads ON_CYCLES-1.
- ON, timer=0 → GAP. The timer loads GAP_CYCLES-1. Otherwise the timer decrements.
- GAP, timer=0:
  - pending>0 → ON, pending−1.
  - pending=0 and event_i → ON, pending unchanged (the event is consumed directly).
  - otherwise → IDLE.
- Events while in ON or GAP increment pending, except in the GAP-exit cycle handled above.
- Simultaneous event and decrement at GAP exit: pending unchanged.
- Saturation: an event when pending=MAX_PENDING and it is not consumed in that cycle is dropped, and overflow←1.
- overflow clears only on clear or reset.
- clear has priority over everything:
  - next state is IDLE, with pending=0, overflow=0 and timer=0.
  - An event_i in the same cycle is discarded.
  - A pulse in progress is truncated.
- Timer width is $clog2(max(ON_CYCLES,GAP_CYCLES)). Use a minimum width of 1. It never wraps: each load happens only at zero.

## Timing
- Reset values: led=0, busy=0, pending=0, overflow=0, state=IDLE, timer=0. Reset is applied asynchronously; release is synchronous to clk.
- Latency:
  - An event sampled at edge T (idle) gives led=1 from cycle T+1 through T+ON_CYCLES.
  - led=0 for cycles T+ON_CYCLES+1 … T+ON_CYCLES+GAP_CYCLES.
  - busy drops at T+ON_CYCLES+GAP_CYCLES+1 if nothing is queued.
- Back-to-back replay period is ON_CYCLES+GAP_CYCLES. There is no extra idle cycle between gap and the next pulse.
- pending changes one cycle after the event edge, and one cycle after GAP exit on consumption.
- clear at edge T: led=0, busy=0 and pending=0 from T+1.
- rst_n assertion mid-pulse: led=0 immediately (asynchronous), with no wait for a clk edge.

## Structure
- pulse_stretcher_pkg holds the state typedef enum logic [1:0] {IDLE, ON, GAP}.
- Sub-module cycle_timer: a loadable down-counter.
  - Ports: clk, rst_n, load, load_val, zero.
  - Parameter: WIDTH.
  - Used for both ON and GAP intervals.
- Top module contains the FSM, the saturating pending counter and the overflow flag.

## Test plan
(All scenarios use ON_CYCLES=8, GAP_CYCLES=4, MAX_PENDING=3.)
- **Reset:** hold rst_n=0 with event_i toggling → led=0, busy=0, pending=0, overflow=0 throughout.
- **Single event:** event_i high at cycle 10 only → led=1 for cycles 11–18, led=0 for 19–22 with busy=1, busy=0 at 23.
- **Burst:** event_i high at cycles 10–13 →
  - pending reaches 3 by cycle 14.
  - led=1 for 11–18, 23–30, 35–42 and 47–54.
  - pending reads 2/1/0 from cycles 23/35/47.
  - overflow stays 0.
- **Saturation and clear:** event_i high at cycles 10–14 →
  - pending=3 and overflow=1 from cycle 15.
  - clear at cycle 20 gives led=0, busy=0, pending=0, overflow=0 at 21.
  - clear and event_i together leave the block idle.
- **GAP-exit event:** single event at cycle 10, then a second event at cycle 22 (last GAP cycle) → led=1 for 23–30 directly, pending stays 0 the whole time.
- **Async reset mid-pulse:** event at cycle 10, rst_n=0 at mid-cycle 14 → led falls before the next clk edge. After release, an event at cycle 30 gives a clean 8-cycle pulse 31–38.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Timer wide enough for the longer of the two intervals, never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; used for both the ON and GAP intervals.
module cycle_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into fixed ON/GAP LED pulses, queueing events that
// arrive mid-pulse in a saturating counter and flagging any that had to be dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               event_i,
  input  logic                               clear,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int unsigned PW = $clog2(MAX_PENDING + 1);
  localparam int unsigned TW = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] OnLoad  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GapLoad = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PendMax = PW'(MAX_PENDING);

  state_e          state_q;
  logic [PW-1:0]   pending_q;
  logic            overflow_q;
  logic            zero;
  logic            load;
  logic [TW-1:0]   load_val;
  logic            gap_exit;
  logic            ev_queue;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // The last GAP cycle is handled by the exit logic, so events there are not queued.
  assign gap_exit = (state_q == GAP) && zero;
  assign ev_queue = event_i && !clear &&
                    ((state_q == ON) || ((state_q == GAP) && !zero));

  always_comb begin
    load     = 1'b0;
    load_val = '0;
    if (clear) begin
      load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (event_i) begin
            load     = 1'b1;
            load_val = OnLoad;
          end
        end
        ON: begin
          if (zero) begin
            load     = 1'b1;
            load_val = GapLoad;
          end
        end
        GAP: begin
          if (zero && ((pending_q != '0) || event_i)) begin
            load     = 1'b1;
            load_val = OnLoad;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (event_i) state_q <= ON;
        ON:   if (zero) state_q <= GAP;
        GAP: begin
          if (gap_exit) begin
            if (pending_q != '0) begin
              state_q <= ON;
              // A new event in the same cycle replaces the one being replayed.
              if (!event_i) pending_q <= pending_q - PW'(1);
            end else if (event_i) begin
              state_q <= ON;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (ev_queue) begin
        if (pending_q == PendMax) overflow_q <= 1'b1;
        else                      pending_q  <= pending_q + PW'(1);
      end
    end
  end

  assign led      = (state_q == ON);
  assign busy     = (state_q != IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios for pulse_stretcher with a per-cycle expectation queue and an
// independent monitor that checks each queued expectation against the DUT outputs.
module tb_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic       event_i;
  logic       clear;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
  } exp_t;

  typedef struct {
    int   scn;
    int   cyc;
    exp_t val;
  } sb_t;

  sb_t sb[$];
  int  checks;
  int  errors;

  pulse_stretcher #(
    .ON_CYCLES   (8),
    .GAP_CYCLES  (4),
    .MAX_PENDING (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_i  (event_i),
    .clear    (clear),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_r(int c, int a, int b);
    return (c >= a) && (c <= b);
  endfunction

  function automatic int len_of(int scn);
    case (scn)
      1: return 10;
      2: return 26;
      3: return 62;
      4: return 26;
      5: return 38;
      default: return 44;
    endcase
  endfunction

  // Inputs sampled at edge c.
  function automatic logic ev_of(int scn, int c);
    case (scn)
      1: return logic'(c % 2);
      2: return c == 10;
      3: return in_r(c, 10, 13);
      4: return in_r(c, 10, 14) || (c == 20);
      5: return (c == 10) || (c == 22);
      default: return (c == 10) || (c == 30);
    endcase
  endfunction

  function automatic logic clr_of(int scn, int c);
    return (scn == 4) && (c == 20);
  endfunction

  function automatic logic rstn_of(int scn, int c);
    if (scn == 1) return 1'b0;
    if (scn == 6) return !in_r(c, 14, 19);
    return 1'b1;
  endfunction

  // Hand-derived outputs visible during cycle c (i.e. after edge c-1).
  function automatic exp_t exp_of(int scn, int c);
    exp_t e;
    e = '0;
    case (scn)
      2: begin
        e.led  = in_r(c, 11, 18);
        e.busy = in_r(c, 11, 22);
      end
      3: begin
        e.led  = in_r(c, 11, 18) || in_r(c, 23, 30) || in_r(c, 35, 42) || in_r(c, 47, 54);
        e.busy = in_r(c, 11, 58);
        if (c == 12) e.pending = 2'd1;
        else if (c == 13) e.pending = 2'd2;
        else if (in_r(c, 14, 22)) e.pending = 2'd3;
        else if (in_r(c, 23, 34)) e.pending = 2'd2;
        else if (in_r(c, 35, 46)) e.pending = 2'd1;
      end
      4: begin
        e.led      = in_r(c, 11, 18);
        e.busy     = in_r(c, 11, 20);
        e.overflow = in_r(c, 15, 20);
        if (c == 12) e.pending = 2'd1;
        else if (c == 13) e.pending = 2'd2;
        else if (in_r(c, 14, 20)) e.pending = 2'd3;
      end
      5: begin
        e.led  = in_r(c, 11, 18) || in_r(c, 23, 30);
        e.busy = in_r(c, 11, 34);
      end
      6: begin
        e.led  = in_r(c, 11, 14) || in_r(c, 31, 38);
        e.busy = in_r(c, 11, 14) || in_r(c, 31, 42);
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: one expectation is presented per cycle, checked just after the edge.
  initial begin
    sb_t  s;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        s   = sb.pop_front();
        got = '{led, busy, pending, overflow};
        checks++;
        if (got !== s.val) begin
          errors++;
          $display("FAIL scn%0d cycle %0d: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                   s.scn, s.cyc, got.led, got.busy, got.pending, got.overflow,
                   s.val.led, s.val.busy, s.val.pending, s.val.overflow);
        end
      end
    end
  end

  task automatic run_scn(input int scn);
    sb_t s;
    @(negedge clk);
    rst_n   = 1'b0;
    event_i = 1'b0;
    clear   = 1'b0;
    @(negedge clk);
    rst_n = rstn_of(scn, 0);
    for (int c = 0; c <= len_of(scn); c++) begin
      @(negedge clk);
      rst_n   = rstn_of(scn, c);
      event_i = ev_of(scn, c);
      clear   = clr_of(scn, c);
      s.scn   = scn;
      s.cyc   = c + 1;
      s.val   = exp_of(scn, c + 1);
      sb.push_back(s);
      if (scn == 6 && c == 14) begin
        // Reset landed mid-cycle; the LED must already be dark before the next edge.
        #1;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: got led=%b busy=%b, want led=0 busy=0", led, busy);
        end
      end
    end
    @(posedge clk);
    #2;
    event_i = 1'b0;
    clear   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    event_i = 1'b0;
    clear   = 1'b0;
    for (int scn = 1; scn <= 6; scn++) run_scn(scn);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
